// File: rtl/menu_host_responder.sv
// Far end of the display menu's UART link: decodes button bytes, streams text pages
// (clear, "PG xx" header, ROWS name lines) and strobes ROM-load / menu-close to the loader.
module menu_host_responder #(
    parameter int ROWS     = 16,
    parameter int NAME_LEN = 16,
    parameter int IDX_W    = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_ready,
    output logic [7:0]                          tx_data,
    output logic                                tx_start,
    input  logic                                tx_busy,
    input  logic [IDX_W:0]                      entry_count,
    output logic [IDX_W+$clog2(NAME_LEN)-1:0]   name_addr,
    input  logic [7:0]                          name_data,
    output logic [IDX_W-1:0]                    page,
    output logic [IDX_W-1:0]                    rom_select,
    output logic                                rom_load,
    output logic                                menu_close,
    output logic                                refreshing
);
    localparam int COL_W = $clog2(NAME_LEN);
    localparam int ROW_W = $clog2(ROWS);
    localparam int EW    = IDX_W + ROW_W + 1;
    localparam logic [COL_W:0]   COL_NL   = (COL_W+1)'(NAME_LEN);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [7:0]       SEL_MAX  = 8'(ROWS);

    // Handshake: tx_start is a one-cycle request issued only while tx_busy=0; the
    // transmitter raises tx_busy from the following cycle until the byte is out.
    // rx_ready is a one-cycle strobe qualifying rx_data; there is no back-pressure.
    typedef enum logic [2:0] {IDLE, CLEAR, HDR, FETCH, SEND, WAIT_TX} state_t;
    state_t state, state_next;

    logic [2:0]       hdr_idx;
    logic             body;
    logic [ROW_W-1:0] row;
    logic [COL_W:0]   col;
    logic             fetch_ph;
    logic             wait_first;
    logic             pend_vld;
    logic [7:0]       pend_byte;

    logic             send_fire;
    logic             wait_done;
    logic [7:0]       hdr_byte;
    logic [7:0]       page8;
    logic [IDX_W+ROW_W-1:0] ent;
    logic             ent_valid;

    logic             cmd_vld;
    logic [7:0]       cmd;
    logic             is_next, is_prev, is_home, is_close, is_sel, sel_ok;
    logic [IDX_W+ROW_W-1:0] sel_ent;
    logic [EW-1:0]    np_sum;
    logic [IDX_W-1:0] last_page;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign page8      = 8'(page);
    assign ent        = {page, row};
    assign ent_valid  = EW'(ent) < EW'(entry_count);
    assign name_addr  = {ent[IDX_W-1:0], col[COL_W-1:0]};
    assign refreshing = (state != IDLE);
    assign tx_start   = send_fire & reset;
    assign wait_done  = (state == WAIT_TX) && !wait_first && !tx_busy;

    // A byte arriving in IDLE takes priority over the stored one (last byte wins).
    assign cmd_vld  = rx_ready | pend_vld;
    assign cmd      = rx_ready ? rx_data : pend_byte;
    assign is_next  = (cmd == 8'h81);
    assign is_prev  = (cmd == 8'h80);
    assign is_home  = (cmd == 8'h82);
    assign is_close = (cmd == 8'h83);
    assign is_sel   = (cmd != 8'h00) && (cmd <= SEL_MAX);
    assign sel_ent  = {page, ROW_W'(cmd - 8'd1)};
    assign sel_ok   = is_sel && (EW'(sel_ent) < EW'(entry_count));

    // An empty ROM list still shows one (blank) page.
    assign np_sum    = EW'(entry_count) + EW'(ROWS - 1);
    assign last_page = (np_sum < EW'(ROWS)) ? '0 : IDX_W'((np_sum >> ROW_W) - EW'(1));

    always_comb begin
        hdr_byte = 8'h0A;
        case (hdr_idx)
            3'd1:    hdr_byte = 8'h50;
            3'd2:    hdr_byte = 8'h47;
            3'd3:    hdr_byte = 8'h20;
            3'd4:    hdr_byte = hex_char(page8[7:4]);
            3'd5:    hdr_byte = hex_char(page8[3:0]);
            default: hdr_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= CLEAR;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        send_fire  = 1'b0;
        case (state)
            IDLE:  if (cmd_vld && (is_next || is_prev || is_home)) state_next = CLEAR;
            CLEAR: state_next = SEND;
            HDR:   state_next = SEND;
            FETCH: if ((col == COL_NL) || !ent_valid || fetch_ph) state_next = SEND;
            SEND: begin
                if (!tx_busy) begin
                    send_fire  = 1'b1;
                    state_next = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (wait_done) begin
                    if (!body)                                  state_next = (hdr_idx == 3'd6) ? FETCH : HDR;
                    else if ((col == COL_NL) && (row == ROW_LAST)) state_next = IDLE;
                    else                                        state_next = FETCH;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_data    <= 8'h00;
            page       <= '0;
            rom_select <= '0;
            rom_load   <= 1'b0;
            menu_close <= 1'b0;
            pend_vld   <= 1'b0;
            pend_byte  <= 8'h00;
            hdr_idx    <= 3'd0;
            body       <= 1'b0;
            row        <= '0;
            col        <= '0;
            fetch_ph   <= 1'b0;
            wait_first <= 1'b0;
        end else begin
            rom_load   <= 1'b0;
            menu_close <= 1'b0;
            if (state != IDLE && rx_ready) begin
                pend_vld  <= 1'b1;
                pend_byte <= rx_data;
            end
            case (state)
                IDLE: begin
                    pend_vld <= 1'b0;
                    if (cmd_vld) begin
                        if (is_next)       page <= (page == last_page) ? '0 : page + 1'b1;
                        else if (is_prev)  page <= (page == '0) ? last_page : page - 1'b1;
                        else if (is_home)  page <= '0;
                        else if (is_close) menu_close <= 1'b1;
                        else if (sel_ok) begin
                            rom_select <= sel_ent[IDX_W-1:0];
                            rom_load   <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    tx_data <= 8'h0C;
                    hdr_idx <= 3'd0;
                    body    <= 1'b0;
                end
                HDR: tx_data <= hdr_byte;
                FETCH: begin
                    if (col == COL_NL)  tx_data <= 8'h0A;
                    else if (!ent_valid) tx_data <= 8'h20;
                    else if (fetch_ph) begin
                        tx_data  <= name_data;
                        fetch_ph <= 1'b0;
                    end else begin
                        fetch_ph <= 1'b1;
                    end
                end
                SEND: wait_first <= 1'b1;
                WAIT_TX: begin
                    wait_first <= 1'b0;
                    if (wait_done) begin
                        if (!body) begin
                            if (hdr_idx == 3'd6) begin
                                body <= 1'b1;
                                row  <= '0;
                                col  <= '0;
                            end else begin
                                hdr_idx <= hdr_idx + 3'd1;
                            end
                        end else if (col == COL_NL) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_menu_host_responder.sv
// Bench for menu_host_responder: UART transmitter and name memory models, a page-text
// reference built from the menu rules, directed scenarios and a randomized command phase.
module tb_menu_host_responder;
  localparam int ROWS = 16;
  localparam int NAME_LEN = 16;
  localparam int IDX_W = 8;
  localparam int AW = IDX_W + $clog2(NAME_LEN);

  logic clk, reset;
  logic [7:0] rx_data, tx_data, name_data;
  logic rx_ready, tx_start, tx_busy, rom_load, menu_close, refreshing;
  logic [IDX_W:0] entry_count;
  logic [AW-1:0] name_addr;
  logic [IDX_W-1:0] page, rom_select;

  menu_host_responder #(.ROWS(ROWS), .NAME_LEN(NAME_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .entry_count(entry_count), .name_addr(name_addr), .name_data(name_data),
    .page(page), .rom_select(rom_select), .rom_load(rom_load),
    .menu_close(menu_close), .refreshing(refreshing)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // name memory, one-cycle read latency
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) name_data <= mem[name_addr];

  // transmitter model
  int busy_cnt = 0;
  int busy_lo = 10;
  int busy_hi = 10;
  logic hold = 1'b0;
  assign tx_busy = (busy_cnt != 0) || hold;
  always @(posedge clk) begin
    if (tx_start && !tx_busy) busy_cnt <= $urandom_range(busy_hi, busy_lo);
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // monitor
  logic [7:0] got_q[$];
  int start_cnt = 0, load_cnt = 0, close_cnt = 0, overlap_cnt = 0;
  always @(negedge clk) begin
    if (tx_start) begin
      got_q.push_back(tx_data);
      start_cnt++;
    end
    if (rom_load) load_cnt++;
    if (menu_close) close_cnt++;
    if (rom_load && menu_close) overlap_cnt++;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[n];
  endfunction

  function automatic int np_of(input int ec);
    return (ec == 0) ? 1 : (ec + ROWS - 1) / ROWS;
  endfunction

  task automatic build(input int pg, input int ec);
    exp_q.delete();
    exp_q.push_back(8'h0C);
    exp_q.push_back("P");
    exp_q.push_back("G");
    exp_q.push_back(" ");
    exp_q.push_back(hexc((pg / 16) % 16));
    exp_q.push_back(hexc(pg % 16));
    exp_q.push_back(8'h0A);
    for (int r = 0; r < ROWS; r++) begin
      int e;
      e = pg * ROWS + r;
      for (int c = 0; c < NAME_LEN; c++)
        exp_q.push_back((e < ec) ? mem[e * NAME_LEN + c] : 8'h20);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic check_stream(input string tag);
    int bad, first;
    bad = 0;
    first = -1;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    if (first >= 0) $display("note %s: first differing byte at index %0d", tag, first);
    check({tag, "_bytes_wrong"}, bad, 0);
  endtask

  // driver tasks
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (refreshing && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, refreshing, 1'b0);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic set_reset(input logic v);
    @(posedge clk);
    #1 reset = v;
  endtask

  int m_page, m_sel, ec, s, bl, bc;
  logic [7:0] code;
  logic [7:0] dir_cmds [3];

  initial begin
    reset = 1'b0;
    rx_ready = 1'b0;
    rx_data = 8'h00;
    entry_count = 20;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom_range(8'h21, 8'h7E));
    repeat (3) @(negedge clk);

    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_page", page, 0);
    check("rst_rom_select", rom_select, 0);
    check("rst_rom_load", rom_load, 1'b0);
    check("rst_menu_close", menu_close, 1'b0);
    check("rst_no_starts", start_cnt, 0);

    got_q.delete();
    set_reset(1'b1);
    @(negedge clk);
    check("refresh_after_release", refreshing, 1'b1);
    m_page = 0;
    m_sel = 0;
    build(0, 20);
    wait_idle("boot");
    check_stream("boot_page0");

    // page navigation 0x81, 0x81, 0x80 -> 1, 0, 1
    dir_cmds[0] = 8'h81;
    dir_cmds[1] = 8'h81;
    dir_cmds[2] = 8'h80;
    for (int k = 0; k < 3; k++) begin
      got_q.delete();
      send_rx(dir_cmds[k]);
      m_page = (k == 1) ? 0 : 1;
      check("nav_page", page, m_page);
      build(m_page, 20);
      wait_idle("nav");
      check_stream("nav_stream");
    end

    // selection on page 1
    bl = load_cnt;
    send_rx(8'h03);
    repeat (2) @(negedge clk);
    check("sel3_load_count", load_cnt - bl, 1);
    check("sel3_rom_select", rom_select, 18);
    m_sel = 18;
    send_rx(8'h06);
    repeat (3) @(negedge clk);
    check("sel6_ignored", load_cnt - bl, 1);
    check("sel6_rom_select", rom_select, 18);
    check("sel6_no_refresh", refreshing, 1'b0);

    // commands during refresh: last byte wins
    got_q.delete();
    send_rx(8'h81);
    m_page = 0;
    build(0, 20);
    repeat (30) @(negedge clk);
    send_rx(8'h81);
    repeat (5) @(negedge clk);
    bc = close_cnt;
    bl = load_cnt;
    send_rx(8'h83);
    wait_idle("pend");
    repeat (4) @(negedge clk);
    check("pend_close_pulse", close_cnt - bc, 1);
    check("pend_no_load", load_cnt - bl, 0);
    check("pend_page_kept", page, 0);
    check("pend_no_refresh", refreshing, 1'b0);
    check_stream("pend_stream");

    // transmitter stall
    got_q.delete();
    send_rx(8'h82);
    build(0, 20);
    repeat (60) @(negedge clk);
    @(posedge clk);
    #1 hold = 1'b1;
    @(negedge clk);
    s = start_cnt;
    repeat (200) @(negedge clk);
    check("stall_no_start", start_cnt - s, 0);
    @(posedge clk);
    #1 hold = 1'b0;
    wait_idle("stall");
    check_stream("stall_stream");

    // reset in the middle of a refresh
    send_rx(8'h81);
    repeat (100) @(negedge clk);
    set_reset(1'b0);
    got_q.delete();
    s = start_cnt;
    repeat (5) @(negedge clk);
    check("midrst_no_start", start_cnt - s, 0);
    check("midrst_page", page, 0);
    check("midrst_rom_select", rom_select, 0);
    set_reset(1'b1);
    m_page = 0;
    m_sel = 0;
    build(0, 20);
    wait_idle("midrst");
    check_stream("midrst_stream");

    // randomized configurations and commands
    busy_lo = 1;
    busy_hi = 4;
    for (int cfg = 0; cfg < 3; cfg++) begin
      ec = (cfg == 0) ? 0 : $urandom_range(1, 60);
      set_reset(1'b0);
      entry_count = (IDX_W+1)'(ec);
      repeat (2) @(negedge clk);
      got_q.delete();
      set_reset(1'b1);
      m_page = 0;
      m_sel = 0;
      build(0, ec);
      wait_idle("rnd_boot");
      check_stream("rnd_boot_stream");
      for (int k = 0; k < 6; k++) begin
        bit refresh, exp_load, exp_close;
        int e;
        case ($urandom_range(0, 5))
          0: code = 8'h81;
          1: code = 8'h80;
          2: code = 8'h82;
          3: code = 8'h83;
          4: code = 8'($urandom_range(1, ROWS));
          default: code = 8'($urandom_range(0, 255));
        endcase
        refresh = 0;
        exp_load = 0;
        exp_close = 0;
        if (code == 8'h81) begin
          m_page = (m_page + 1) % np_of(ec);
          refresh = 1;
        end else if (code == 8'h80) begin
          m_page = (m_page + np_of(ec) - 1) % np_of(ec);
          refresh = 1;
        end else if (code == 8'h82) begin
          m_page = 0;
          refresh = 1;
        end else if (code == 8'h83) begin
          exp_close = 1;
        end else if (code >= 1 && code <= ROWS) begin
          e = m_page * ROWS + int'(code) - 1;
          if (e < ec) begin
            exp_load = 1;
            m_sel = e;
          end
        end
        got_q.delete();
        bl = load_cnt;
        bc = close_cnt;
        send_rx(code);
        if (refresh) begin
          build(m_page, ec);
          wait_idle("rnd_cmd");
          check_stream("rnd_cmd_stream");
        end else begin
          repeat (4) @(negedge clk);
          check("rnd_no_refresh", refreshing, 1'b0);
        end
        check("rnd_page", page, m_page);
        check("rnd_load_count", load_cnt - bl, exp_load);
        check("rnd_close_count", close_cnt - bc, exp_close);
        check("rnd_rom_select", rom_select, m_sel);
      end
    end

    check("load_close_overlap", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
